// File: rtl/stream_mux_n_1_if.sv
// Handshake bundle for stream_mux_n_1: select controls, N input channels and one output stream.
interface stream_mux_n_1_if #(
   parameter int N_CH  = 4,
   parameter int W     = 4,
   parameter int SEL_W = $clog2(N_CH)
);
   logic                mode;
   logic [SEL_W-1:0]    sel;
   logic [N_CH-1:0]     in_valid;
   logic [N_CH*W-1:0]   in_data;
   logic [N_CH-1:0]     in_ready;
   logic                out_valid;
   logic [W-1:0]        out_data;
   logic [SEL_W-1:0]    out_ch;
   logic                out_ready;

   modport master (
      output mode, sel, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_ch
   );

   modport slave (
      input  mode, sel, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_ch
   );
endinterface

// File: rtl/stream_mux_n_1.sv
// N:1 valid/ready stream mux, fixed-select or round-robin, registered output.
// Define STREAM_MUX_SKID_EN to add a one-entry skid buffer that cuts out_ready -> in_ready.
module stream_mux_n_1 #(
   parameter int N_CH = 4,
   parameter int W    = 4
) (
   input logic             clk,
   input logic             rst_n,
   stream_mux_n_1_if.slave strm
);
   localparam int SEL_W = $clog2(N_CH);

   logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
   logic             out_vld_q, out_vld_d;
   logic [W-1:0]     out_data_q, out_data_d;
   logic [SEL_W-1:0] out_ch_q, out_ch_d;

   logic [SEL_W-1:0] gnt;
   logic             gnt_vld;
   logic [W-1:0]     gnt_data;
   logic [N_CH-1:0]  rdy;
   logic [N_CH-1:0]  vld_rot;
   int               idx;
   logic             can_acc;
   logic             acc_ok;
   logic             xfer;

   // Round-robin scan starts at rr_ptr and wraps; first requester wins.
   always_comb begin
      gnt     = '0;
      gnt_vld = 1'b0;
      idx     = 0;
      vld_rot = '0;
      if (!strm.mode) begin
         gnt     = strm.sel;
         gnt_vld = (int'(strm.sel) < N_CH);
      end else begin
         for (int k = 0; k < N_CH; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_CH) idx = idx - N_CH;
            vld_rot = strm.in_valid >> idx;
            if (!gnt_vld && vld_rot[0]) begin
               gnt_vld = 1'b1;
               gnt     = SEL_W'(idx);
            end
         end
      end
   end

   always_comb begin
      gnt_data = '0;
      rdy      = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (gnt == SEL_W'(k)) begin
            gnt_data = strm.in_data[k*W +: W];
            rdy[k]   = acc_ok;
         end
      end
   end

   assign acc_ok        = rst_n && gnt_vld && can_acc;
   assign xfer          = |(rdy & strm.in_valid);
   assign strm.in_ready = rdy;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (xfer && strm.mode)
         rr_ptr_d = (int'(gnt) == N_CH - 1) ? '0 : gnt + SEL_W'(1);
   end

`ifdef STREAM_MUX_SKID_EN
   logic             skid_vld_q, skid_vld_d;
   logic [W-1:0]     skid_data_q, skid_data_d;
   logic [SEL_W-1:0] skid_ch_q, skid_ch_d;

   // Acceptance looks only at the registered skid flag, so a stalled output
   // can still absorb exactly one more word.
   assign can_acc = !skid_vld_q;

   always_comb begin
      out_vld_d   = out_vld_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      skid_vld_d  = skid_vld_q;
      skid_data_d = skid_data_q;
      skid_ch_d   = skid_ch_q;
      if (out_vld_q && !strm.out_ready) begin
         if (xfer) begin
            skid_vld_d  = 1'b1;
            skid_data_d = gnt_data;
            skid_ch_d   = gnt;
         end
      end else if (skid_vld_q) begin
         out_vld_d  = 1'b1;
         out_data_d = skid_data_q;
         out_ch_d   = skid_ch_q;
         skid_vld_d = 1'b0;
      end else begin
         out_vld_d = xfer;
         if (xfer) begin
            out_data_d = gnt_data;
            out_ch_d   = gnt;
         end
      end
   end

   always_ff @(posedge clk) begin
      skid_data_q <= skid_data_d;
      skid_ch_q   <= skid_ch_d;
      if (!rst_n) skid_vld_q <= 1'b0;
      else        skid_vld_q <= skid_vld_d;
   end
`else
   assign can_acc = !out_vld_q || strm.out_ready;

   always_comb begin
      out_vld_d  = out_vld_q;
      out_data_d = out_data_q;
      out_ch_d   = out_ch_q;
      if (xfer) begin
         out_vld_d  = 1'b1;
         out_data_d = gnt_data;
         out_ch_d   = gnt;
      end else if (strm.out_ready) begin
         out_vld_d = 1'b0;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr_q   <= '0;
         out_vld_q  <= 1'b0;
         out_data_q <= '0;
         out_ch_q   <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         out_vld_q  <= out_vld_d;
         out_data_q <= out_data_d;
         out_ch_q   <= out_ch_d;
      end
   end

   assign strm.out_valid = out_vld_q;
   assign strm.out_data  = out_data_q;
   assign strm.out_ch    = out_ch_q;
endmodule
